// File: rtl/handshake_echo_app_multi.sv
// Handshake echo responder: RX header FIFO -> registered flow-table lookup -> held reply header.
// Optional macro HANDSHAKE_ECHO_OVF_CNT_EN implements rx_overflow_cnt; otherwise it reads 0.
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif
`ifndef FLOW_ID_W
`define FLOW_ID_W 4
`endif
`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef FLOW_LOOKUP_ENTRY_WIDTH
`define FLOW_LOOKUP_ENTRY_WIDTH 64
`endif

module handshake_echo_app_multi #(
    parameter int          RX_FIFO_DEPTH = 16,
    parameter int          REPLY_MODE    = 0,
    parameter logic [31:0] ACK_INCR      = 32'd1,
    parameter logic [31:0] ISN           = 32'h0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                engine_recv_header_val,
    input  logic [`TCP_HEADER_WIDTH-1:0]        engine_recv_tcp_hdr,
    input  logic [`FLOW_ID_W-1:0]               engine_recv_flowid,
    input  logic                                new_idtoaddr_lookup_val,
    input  logic [`FLOW_ID_W-1:0]               new_idtoaddr_lookup_flow_id,
    input  logic [`FLOW_LOOKUP_ENTRY_WIDTH-1:0] new_idtoaddr_lookup_entry,
    output logic                                tx_tcp_hdr_val,
    output logic [`IP_ADDR_WIDTH-1:0]           tx_src_ip,
    output logic [`IP_ADDR_WIDTH-1:0]           tx_dst_ip,
    output logic [`TCP_HEADER_WIDTH-1:0]        tx_tcp_hdr,
    input  logic                                tx_tcp_hdr_rdy,
    output logic [15:0]                         rx_overflow_cnt,
    output logic [15:0]                         filtered_cnt
);
    localparam int HW = `TCP_HEADER_WIDTH;
    localparam int FW = `FLOW_ID_W;
    localparam int EW = `FLOW_LOOKUP_ENTRY_WIDTH;
    localparam int IW = `IP_ADDR_WIDTH;
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int TABLE_SIZE = 1 << FW;
    // Header field MSB positions (tcp_packet_header packed MSB-first)
    localparam int SPORT_MSB = HW - 1;
    localparam int DPORT_MSB = HW - 17;
    localparam int SEQ_MSB   = HW - 33;
    localparam int ACK_MSB   = HW - 65;
    localparam int FLAGS_MSB = HW - 105;
    localparam int SYN_BIT   = FLAGS_MSB - 6;

    typedef enum logic [1:0] {IDLE, LOOKUP, OUTPUT} state_t;
    state_t state_reg, state_next;

    // Receive FIFO: pointers carry one extra wrap bit
    logic [HW-1:0] fifo_hdr_mem  [RX_FIFO_DEPTH];
    logic [FW-1:0] fifo_flow_mem [RX_FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          fifo_empty, fifo_full, push, pop, accept, filter;
    logic [HW-1:0] head_hdr, reply_hdr;
    logic [FW-1:0] head_flow;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // Fullness is sampled before any same-cycle pop, so a push while full is always dropped
    assign push      = engine_recv_header_val && !fifo_full;
    assign head_hdr  = fifo_hdr_mem[rd_ptr_reg[AW-1:0]];
    assign head_flow = fifo_flow_mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_hdr_mem[wr_ptr_reg[AW-1:0]]  <= engine_recv_tcp_hdr;
            fifo_flow_mem[wr_ptr_reg[AW-1:0]] <= engine_recv_flowid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Flow table, one row per flow id
    logic [EW-1:0] table_mem [TABLE_SIZE];
    logic [EW-1:0] table_rd_reg;

    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_table_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    table_mem[gi] <= '0;
                else if (new_idtoaddr_lookup_val && new_idtoaddr_lookup_flow_id == FW'(gi))
                    table_mem[gi] <= new_idtoaddr_lookup_entry;
            end
        end
    endgenerate

    always_comb begin
        reply_hdr = head_hdr;
        reply_hdr[SPORT_MSB -: 16] = head_hdr[DPORT_MSB -: 16];
        reply_hdr[DPORT_MSB -: 16] = head_hdr[SPORT_MSB -: 16];
        if (REPLY_MODE == 1) begin
            reply_hdr[FLAGS_MSB -: 8] = 8'h12;
            reply_hdr[SEQ_MSB -: 32]  = ISN;
            reply_hdr[ACK_MSB -: 32]  = head_hdr[SEQ_MSB -: 32] + 32'd1;
        end else begin
            reply_hdr[ACK_MSB -: 32]  = head_hdr[ACK_MSB -: 32] + ACK_INCR;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        accept     = 1'b0;
        filter     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (REPLY_MODE == 1 && !head_hdr[SYN_BIT]) begin
                        filter = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = LOOKUP;
                    end
                end
            end
            LOOKUP:  state_next = OUTPUT;
            OUTPUT:  if (tx_tcp_hdr_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [HW-1:0] hdr_reg, tx_hdr_reg;
    logic [IW-1:0] tx_src_ip_reg, tx_dst_ip_reg;
    logic [15:0]   filtered_cnt_reg;

    // The table entry is read at pop time, so later writes cannot reach this reply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            hdr_reg          <= '0;
            table_rd_reg     <= '0;
            tx_hdr_reg       <= '0;
            tx_src_ip_reg    <= '0;
            tx_dst_ip_reg    <= '0;
            filtered_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                hdr_reg      <= reply_hdr;
                table_rd_reg <= table_mem[head_flow];
            end
            if (state_reg == LOOKUP) begin
                tx_hdr_reg    <= hdr_reg;
                tx_src_ip_reg <= table_rd_reg[EW-1 -: IW];
                tx_dst_ip_reg <= table_rd_reg[IW-1:0];
            end
            if (filter && filtered_cnt_reg != 16'hFFFF)
                filtered_cnt_reg <= filtered_cnt_reg + 16'd1;
        end
    end

    assign tx_tcp_hdr_val = (state_reg == OUTPUT);
    assign tx_tcp_hdr     = tx_hdr_reg;
    assign tx_src_ip      = tx_src_ip_reg;
    assign tx_dst_ip      = tx_dst_ip_reg;
    assign filtered_cnt   = filtered_cnt_reg;

`ifdef HANDSHAKE_ECHO_OVF_CNT_EN
    logic [15:0] ovf_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt_reg <= '0;
        else if (engine_recv_header_val && fifo_full && ovf_cnt_reg != 16'hFFFF)
            ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end
    assign rx_overflow_cnt = ovf_cnt_reg;
`else
    assign rx_overflow_cnt = 16'h0;
`endif

endmodule
